// File: rtl/elastic_pipe_reg.sv
// Elastic valid/ready register chain (STAGES deep) with flush, bubble collapse, occupancy and stall counter.
// Latency STAGES-1 cycles after the accept edge; ready ripples back combinationally so empty stages always advance.
module elastic_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int STAGES = 2,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  input  logic                          flush,
  output logic [$clog2(STAGES+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]              stall_cnt
);

  localparam int OCC_W = $clog2(STAGES+1);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] adv;
  logic [DATA_W-1:0] d_q [STAGES];
  logic [DATA_W-1:0] d_d [STAGES];
  logic [OCC_W-1:0]  occ_q;
  logic [OCC_W-1:0]  occ_d;
  logic [CNT_W-1:0]  stall_q;
  logic [CNT_W-1:0]  stall_d;
  logic              in_fire;

  // A stage may advance if the one ahead advances or it is itself empty.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = out_ready | ~v_q[STAGES-1];
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = adv[k+1] | ~v_q[k];
    end
  end

  assign in_ready  = adv[0] & ~flush & ~rst;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = v_q[STAGES-1] & ~flush & ~rst;
  assign out_data  = d_q[STAGES-1];
  assign occupancy = occ_q;
  assign stall_cnt = stall_q;

  always_comb begin
    v_d = v_q;
    for (int k = 0; k < STAGES; k++) begin
      d_d[k] = d_q[k];
    end
    if (adv[0]) begin
      v_d[0] = in_fire;
      d_d[0] = in_data;
    end
    for (int k = 1; k < STAGES; k++) begin
      if (adv[k]) begin
        v_d[k] = v_q[k-1];
        d_d[k] = d_q[k-1];
      end
    end
    // Squash only the valid bits; stale data is harmless once invalid.
    if (flush) begin
      v_d = '0;
    end
  end

  always_comb begin
    occ_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_d = occ_d + OCC_W'(v_d[k]);
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q     <= '0;
      occ_q   <= '0;
      stall_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        d_q[k] <= '0;
      end
    end else begin
      v_q     <= v_d;
      occ_q   <= occ_d;
      stall_q <= stall_d;
      for (int k = 0; k < STAGES; k++) begin
        d_q[k] <= d_d[k];
      end
    end
  end

endmodule

// File: tb/tb_elastic_pipe_reg.sv
// Directed bench: a 2-stage chain (stream, backpressure, full pass-through) and a
// 3-stage chain with 4-bit stall counter (bubble collapse, flush, saturation).
module tb_elastic_pipe_reg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_flush;
  logic [31:0] a_in_data, a_out_data;
  logic [1:0]  a_occ;
  logic [15:0] a_stall;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_occ;
  logic [3:0]  b_stall;

  int vectors = 0;
  int miscompares = 0;

  elastic_pipe_reg #(.DATA_W(32), .STAGES(2), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .flush(a_flush), .occupancy(a_occ), .stall_cnt(a_stall)
  );

  elastic_pipe_reg #(.DATA_W(32), .STAGES(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .flush(b_flush), .occupancy(b_occ), .stall_cnt(b_stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b1; a_in_data = 32'hDEAD_BEEF; a_out_ready = 1'b0; a_flush = 1'b0;
    b_in_valid = 1'b1; b_in_data = 32'hDEAD_BEEF; b_out_ready = 1'b0; b_flush = 1'b0;

    // Reset held for two edges with input offered
    tick(); tick();
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_occ",       {30'd0, a_occ}, 32'd0);
    chk("rst_stall",     {16'd0, a_stall}, 32'd0);
    chk("rst_in_ready",  {31'd0, a_in_ready}, 32'd0);
    chk("rst_b_in_ready",{31'd0, b_in_ready}, 32'd0);
    rst = 1'b0; a_in_valid = 1'b0; b_in_valid = 1'b0;

    // Stream on 2 stages
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_data = 32'h8C22_0000;
    #1 chk("s_in_ready", {31'd0, a_in_ready}, 32'd1);
    tick();
    a_in_data = 32'h8C23_0004;
    chk("s_lat_not_yet", {31'd0, a_out_valid}, 32'd0);
    tick();
    a_in_valid = 1'b0;
    chk("s_w0_valid", {31'd0, a_out_valid}, 32'd1);
    chk("s_w0_data",  a_out_data, 32'h8C22_0000);
    chk("s_occ2",     {30'd0, a_occ}, 32'd2);
    tick();
    chk("s_w1_valid", {31'd0, a_out_valid}, 32'd1);
    chk("s_w1_data",  a_out_data, 32'h8C23_0004);
    chk("s_occ1",     {30'd0, a_occ}, 32'd1);
    tick();
    chk("s_drained",  {31'd0, a_out_valid}, 32'd0);
    chk("s_occ0",     {30'd0, a_occ}, 32'd0);

    // Backpressure on 2 stages
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'h1111_AAAA;
    tick();
    a_in_data = 32'h2222_BBBB;
    tick();
    a_in_data = 32'h3333_CCCC;
    for (int i = 0; i < 5; i++) begin
      #1 chk("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
      tick();
      chk("bp_head_data", a_out_data, 32'h1111_AAAA);
    end
    chk("bp_occ",   {30'd0, a_occ}, 32'd2);
    chk("bp_stall", {16'd0, a_stall}, 32'd5);
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    #1 chk("bp_rel_a_valid", {31'd0, a_out_valid}, 32'd1);
    tick();
    chk("bp_rel_b_valid", {31'd0, a_out_valid}, 32'd1);
    chk("bp_rel_b_data",  a_out_data, 32'h2222_BBBB);
    tick();
    chk("bp_empty",      {31'd0, a_out_valid}, 32'd0);
    chk("bp_stall_kept", {16'd0, a_stall}, 32'd5);

    // Full chain with out_ready=1: simultaneous in/out transfer
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'h4444_0001;
    tick();
    a_in_data = 32'h4444_0002;
    tick();
    a_out_ready = 1'b1; a_in_data = 32'h4444_0003;
    #1 chk("full_in_ready", {31'd0, a_in_ready}, 32'd1);
    tick();
    a_in_valid = 1'b0;
    chk("full_occ",  {30'd0, a_occ}, 32'd2);
    chk("full_data", a_out_data, 32'h4444_0002);
    tick();
    chk("full_last", a_out_data, 32'h4444_0003);
    tick();
    chk("full_empty", {31'd0, a_out_valid}, 32'd0);

    // Bubble collapse on 3 stages
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 32'hA000_0001;
    tick();
    b_in_valid = 1'b0;
    tick();
    b_in_valid = 1'b1; b_in_data = 32'hB000_0002;
    tick();
    b_in_valid = 1'b0;
    tick();
    chk("bc_occ",       {30'd0, b_occ}, 32'd2);
    chk("bc_head_data", b_out_data, 32'hA000_0001);
    tick();
    chk("bc_occ_hold",  {30'd0, b_occ}, 32'd2);
    chk("bc_stall",     {28'd0, b_stall}, 32'd2);
    b_out_ready = 1'b1;
    tick();
    chk("bc_b_valid", {31'd0, b_out_valid}, 32'd1);
    chk("bc_b_data",  b_out_data, 32'hB000_0002);
    tick();
    chk("bc_empty",   {31'd0, b_out_valid}, 32'd0);

    // Flush mid-stream on 3 stages
    b_out_ready = 1'b0;
    b_in_valid = 1'b1;
    b_in_data = 32'hC000_0001; tick();
    b_in_data = 32'hC000_0002; tick();
    b_in_data = 32'hC000_0003; tick();
    chk("fl_occ3", {30'd0, b_occ}, 32'd3);
    b_flush = 1'b1; b_in_data = 32'hC000_0004; b_out_ready = 1'b1;
    #1 chk("fl_in_ready",  {31'd0, b_in_ready}, 32'd0);
    chk("fl_out_valid", {31'd0, b_out_valid}, 32'd0);
    tick();
    b_flush = 1'b0; b_in_valid = 1'b0;
    chk("fl_occ0",       {30'd0, b_occ}, 32'd0);
    chk("fl_stall_kept", {28'd0, b_stall}, 32'd2);
    tick(); tick(); tick();
    chk("fl_nothing_out", {31'd0, b_out_valid}, 32'd0);
    b_flush = 1'b1; b_in_valid = 1'b1;
    tick(); tick();
    b_flush = 1'b0; b_in_valid = 1'b0;
    chk("fl_multi_occ", {30'd0, b_occ}, 32'd0);

    // Stall counter saturation at 15
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 32'h5A5A_5A5A;
    tick();
    b_in_valid = 1'b0;
    tick(); tick();
    chk("sat_start", {28'd0, b_stall}, 32'd2);
    for (int i = 0; i < 13; i++) tick();
    chk("sat_reach15", {28'd0, b_stall}, 32'd15);
    for (int i = 0; i < 7; i++) tick();
    chk("sat_hold15", {28'd0, b_stall}, 32'd15);
    chk("sat_data",   b_out_data, 32'h5A5A_5A5A);
    b_out_ready = 1'b1;
    tick();
    chk("sat_drained", {31'd0, b_out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
